// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the bit-serial subtractor.
package sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int SUB_WIDTH = 8;
endpackage

// File: rtl/FS.sv
// FS: single-bit full subtractor cell, port order mirrors the FA cell.
module FS (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic bout,
  output logic d
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - borrow_in one bit per clock with a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic bf, d, bout, last;
  FS u_fs (.a(sa[0]), .b(sb[0]), .bin(bf), .bout(bout), .d(d));
  assign last = cnt == CW'(WIDTH - 1);
  assign oBusy = state != IDLE;
  assign oDone = state == DONE;
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (iStart ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) state <= IDLE;
    else state <= nxt;
  // Outputs load only on the final bit so partial differences never leak out.
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      sa <= '0;
      sb <= '0;
      sr <= '0;
      bf <= 1'b0;
      cnt <= '0;
      oData <= '0;
      oData_B <= 1'b0;
    end else if (state == IDLE && iStart) begin
      sa <= iData_a;
      sb <= iData_b;
      bf <= iB;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sr <= {d, sr[WIDTH-1:1]};
      bf <= bout;
      cnt <= cnt + 1'b1;
      if (last) begin
        oData <= {d, sr[WIDTH-1:1]};
        oData_B <= bout;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for 8- and 16-bit serial subtractors.
module tb_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start8 = 1'b0, bi8 = 1'b0, start16 = 1'b0, bi16 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, data8;
  logic [15:0] a16 = '0, b16 = '0, data16;
  logic busy8, done8, bor8, busy16, done16, bor16;
  logic [8:0] q8[$];
  logic [16:0] q16[$];
  logic [8:0] last_res8 = '0;
  int checks = 0, errors = 0, cyc = 0, last8 = -1, last16 = -1;
  bit stream = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) u8 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start8), .iData_a(a8), .iData_b(b8), .iB(bi8),
    .oBusy(busy8), .oDone(done8), .oData(data8), .oData_B(bor8));
  serial_subtractor #(.WIDTH(16)) u16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start16), .iData_a(a16), .iData_b(b16), .iB(bi16),
    .oBusy(busy16), .oDone(done16), .oData(data16), .oData_B(bor16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("spurious_done8", 1, 0);
      else check("diff8", {23'd0, bor8, data8}, {23'd0, q8.pop_front()});
      if (stream && last8 >= 0) check("gap8", cyc - last8, 10);
      last8 = cyc;
    end
    if (done16) begin
      if (q16.size() == 0) check("spurious_done16", 1, 0);
      else check("diff16", {15'd0, bor16, data16}, {15'd0, q16.pop_front()});
      if (stream && last16 >= 0) check("gap16", cyc - last16, 18);
      last16 = cyc;
    end
  end

  // One 8-bit operation with cycle-exact handshake checks; optional ignored pulse or reset abort.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input int pulse_at, input int rst_at);
    logic [8:0] res;
    res = {1'b0, a} - {1'b0, b} - {8'd0, bi};
    @(negedge clk);
    a8 = a; b8 = b; bi8 = bi; start8 = 1'b1;
    q8.push_back(res);
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_data", {bor8, data8}, 0);
        q8.delete();
        last_res8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check($sformatf("busy_j%0d", j), busy8, j <= 8);
      check($sformatf("done_j%0d", j), done8, j == 8);
      if (j < 8) check($sformatf("hold_j%0d", j), {bor8, data8}, last_res8);
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      start8 = j == pulse_at;
      if (j == pulse_at) begin a8 = 8'hAA; b8 = 8'h55; end
    end
    last_res8 = res;
  endtask

  task automatic stream8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); start8 = 1'b1;
      q8.push_back({1'b0, a8} - {1'b0, b8} - {8'd0, bi8});
      repeat (9) begin
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      end
    end
    start8 = 1'b0;
  endtask

  task automatic stream16(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom); start16 = 1'b1;
      q16.push_back({1'b0, a16} - {1'b0, b16} - {16'd0, bi16});
      repeat (17) begin
        @(negedge clk);
        a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
      end
    end
    start16 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset8", {busy8, done8, bor8, data8}, 0);
    check("reset16", {busy16, done16, bor16, data16}, 0);
    rst_n = 1'b1;
    op8(8'h5A, 8'h3C, 1'b0, -1, -1);
    op8(8'h00, 8'h01, 1'b0, -1, -1);
    op8(8'h00, 8'h00, 1'b1, -1, -1);
    op8(8'h80, 8'h7F, 1'b1, -1, -1);
    op8(8'hFF, 8'h00, 1'b0, -1, -1);
    op8(8'h10, 8'h01, 1'b0, 3, -1);
    op8(8'h37, 8'h12, 1'b1, -1, 5);
    op8(8'h03, 8'h05, 1'b0, -1, -1);
    repeat (3) @(negedge clk);
    stream = 1'b1;
    last8 = -1;
    last16 = -1;
    fork
      stream8(1000);
      stream16(1000);
    join
    for (int t = 0; t < 100 && (q8.size() != 0 || q16.size() != 0); t++) @(negedge clk);
    check("drain", q8.size() + q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
